// File: rtl/truth_table_sequencer_pkg.sv
// Shared types for the truth-table sequencer: FSM state encoding and timer sizing.
package truth_table_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Settle counter width; a zero-cycle settle still needs a 1-bit counter.
    function automatic int tmr_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/truth_table_sequencer_timer.sv
// Loadable down-counter used to hold each vector stable before the output is sampled.
module settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input combination through a combinational circuit, records its
// truth table and compares it against an expected table.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   exp_tt,
    input  logic                 y_in,
    output logic [N_IN-1:0]      vec_out,
    output logic [2**N_IN-1:0]   tt_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 mismatch,
    output logic [N_IN-1:0]      fail_idx
);

    localparam int N_VEC = 2**N_IN;
    localparam int TW    = tmr_width(SETTLE_CYCLES);
    // The timer reads zero on the last settle cycle, hence the load of N-1.
    localparam logic [TW-1:0]   SETTLE_LOAD = (SETTLE_CYCLES > 0) ? TW'(SETTLE_CYCLES - 1) : '0;
    localparam logic [N_IN-1:0] LAST_IDX    = N_IN'(N_VEC - 1);

    state_t            state, state_nx;
    logic [N_IN-1:0]   idx;
    logic [N_VEC-1:0]  exp_q;
    logic              tmr_load, tmr_dec, tmr_zero;
    logic              sample_miss;

    settle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign sample_miss = (y_in != exp_q[idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nx = ST_APPLY;
            end
            ST_APPLY: begin
                tmr_load = 1'b1;
                if (abort)
                    state_nx = ST_IDLE;
                else if (SETTLE_CYCLES > 0)
                    state_nx = ST_SETTLE;
                else
                    state_nx = ST_SAMPLE;
            end
            ST_SETTLE: begin
                tmr_dec = 1'b1;
                if (abort)
                    state_nx = ST_IDLE;
                else if (tmr_zero)
                    state_nx = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)
                    state_nx = ST_IDLE;
                else if (idx == LAST_IDX)
                    state_nx = ST_DONE;
                else
                    state_nx = ST_APPLY;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            exp_q    <= '0;
            vec_out  <= '0;
            tt_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            mismatch <= 1'b0;
            fail_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        exp_q    <= exp_tt;
                        idx      <= '0;
                        vec_out  <= '0;
                        tt_out   <= '0;
                        mismatch <= 1'b0;
                        fail_idx <= '0;
                        pass     <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_APPLY, ST_SETTLE: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        vec_out <= '0;
                        pass    <= 1'b0;
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        vec_out <= '0;
                        pass    <= 1'b0;
                    end else begin
                        tt_out[idx] <= y_in;
                        // Only the first mismatch of a sweep is reported.
                        if (sample_miss && !mismatch) begin
                            mismatch <= 1'b1;
                            fail_idx <= idx;
                        end
                        if (idx == LAST_IDX) begin
                            done <= 1'b1;
                            pass <= ~(mismatch | sample_miss);
                        end else begin
                            idx     <= idx + 1'b1;
                            vec_out <= idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    vec_out <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
